ultrasonic_ranger: RTL
======================

Name: ultrasonic_ranger

Overview:
Front-end ranging stage for one HC-SR04-style ultrasonic sensor. It fires the trigger pulse periodically, times the echo pulse, and converts the echo width to whole centimetres without a divider. Its distance output feeds the motor steering controller and the 7-segment distance display. The car instantiates it three times: front, right and left.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency. CLK_HZ/1_000_000 must be an integer ≥ 1.
- TRIG_US, 10, trigger pulse width in µs.
- PERIOD_MS, 60, interval between successive trigger rising edges in ms.
- TIMEOUT_US, 25_000, maximum wait in µs from trigger fall to echo fall.
- US_PER_CM, 58, echo µs per cm of distance.
- NO_ECHO_CM, 400, value reported on timeout. It is also the saturation value.

Ports:
- clk  in  1  system clock
- reset_p  in  1  reset; asynchronous, active-high
- enable  in  1  when 0, no new trigger is launched; a measurement already in progress completes
- echo  in  1  raw sensor echo pin; asynchronous
- trig  out  1  sensor trigger pin
- distance_cm  out  16  last measured distance, held between updates
- valid  out  1  one-cycle pulse when distance_cm updates
- timeout  out  1  sticky flag; 1 if the last measurement timed out
- busy  out  1  high in TRIG, WAIT_RISE and MEASURE

Behaviour:
- Reset values: trig=0, distance_cm=0, valid=0, timeout=0, busy=0, state=IDLE, all counters 0.
- echo passes through a 2-flop synchroniser, then an edge register. Rise and fall are detected on the synchronised signal, 2 clk after the pin changes.
- µs tick: a prescaler counts 0..CLK_HZ/1e6−1 and emits a tick at the terminal count.
  - It restarts at 0 on entry to TRIG and on detected echo rise.
- Period counter: counts µs ticks free-running from the IDLE entry after reset. It runs independently of the prescaler restarts.
- FSM:
  - IDLE: trig=0. Leave for TRIG when enable=1 and PERIOD_MS×1000 µs have elapsed since the previous TRIG entry. The first trigger after reset fires after one full period.
  - TRIG: trig=1 for exactly TRIG_US ticks, then go to WAIT_RISE. The timeout counter clears on entry.
  - WAIT_RISE: wait for the synchronised echo rising edge; echo already high on entry is not a rise. On rise, go to MEASURE; clear the cm counter and the sub-cm µs counter. On the timeout counter reaching TIMEOUT_US, go to DONE_TO.
  - MEASURE: on each µs tick the sub-cm counter counts 0..US_PER_CM−1. At the wrap, the cm counter increments, saturating at NO_ECHO_CM. The timeout counter keeps running. On echo fall, go to DONE_OK. On timeout, go to DONE_TO; timeout takes priority if both occur in the same cycle.
  - DONE_OK (1 cycle): distance_cm ← cm counter, so the result is truncated, floor(echo_us/US_PER_CM). valid=1, timeout←0, then IDLE.
  - DONE_TO (1 cycle): distance_cm ← NO_ECHO_CM, valid=1, timeout←1, then IDLE.
- Latency: the echo pin falls, and valid and distance_cm update 3 clk later.
- A trigger period that expires while busy is not queued. The next trigger waits for the next period boundary after returning to IDLE.
- enable deasserted mid-measurement: the measurement finishes normally, then the block stays in IDLE.
- reset_p asserted mid-measurement: all outputs return to reset values immediately and asynchronously, including trig=0. The partial measurement is discarded.
- Echo pulses while in IDLE or TRIG are ignored.
- Counter widths: sized from the parameters via $clog2. No wrap-around is permitted before saturation or timeout.

Test Plan:
Use CLK_HZ=1_000_000, PERIOD_MS=2, TIMEOUT_US=1500 and NO_ECHO_CM=20 for speed unless stated.
1. Reset, enable=1, no echo → first trig rise at 2000 µs, high exactly 10 clk. Timeout fires 1500 µs after trig fall: valid pulse with distance_cm=20, timeout=1.
2. Echo high 580 µs, starting 100 µs after trig fall → distance_cm=10, valid 3 clk after echo fall, timeout=0.
3. Echo 1159 µs → distance_cm=19 (truncation). Echo 57 µs → distance_cm=0.
4. Echo held high from before TRIG, never falling → no rise is detected. Timeout gives distance_cm=20, timeout=1. A later good 580 µs echo clears timeout to 0.
5. reset_p pulsed mid-MEASURE → same cycle, trig=0, busy=0, distance_cm=0. No valid pulse for the aborted measurement.
6. enable dropped during MEASURE → that result is still reported. No further trig while enable=0; triggering resumes on the next period boundary after enable=1.

Source files
------------

// File: rtl/ultrasonic_ranger_if.sv
// ultrasonic_ranger_if
//   Signal bundle between one ultrasonic ranging front-end and its user.
//   slave  : the ranger. It takes enable/echo and drives trig plus the result signals.
//   master : the controller/sensor side. Its directions are the mirror of slave.
//   Signals:
//     enable       allow new trigger launches
//     echo         raw, asynchronous sensor echo pin
//     trig         sensor trigger pin
//     distance_cm  last measured distance, held between updates
//     valid        one-cycle strobe on each distance_cm update
//     timeout      sticky, set when the last measurement timed out
//     busy         a measurement is in flight
interface ultrasonic_ranger_if;
  logic        enable;
  logic        echo;
  logic        trig;
  logic [15:0] distance_cm;
  logic        valid;
  logic        timeout;
  logic        busy;

  modport master (
    output enable, echo,
    input  trig, distance_cm, valid, timeout, busy
  );

  modport slave (
    input  enable, echo,
    output trig, distance_cm, valid, timeout, busy
  );
endinterface

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
//   Front end for one HC-SR04-style sensor. It fires a periodic trigger pulse
//   and times the echo pulse. The echo width becomes whole centimetres through
//   a mod-US_PER_CM sub-counter feeding a saturating cm counter, so no divider
//   is needed.
//   Ports:
//     clk      system clock (CLK_HZ)
//     reset_p  asynchronous, active-high reset
//     bus      ultrasonic_ranger_if.slave (enable, echo in; trig, distance_cm,
//              valid, timeout, busy out)
module ultrasonic_ranger #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 25_000,
  parameter int US_PER_CM  = 58,
  parameter int NO_ECHO_CM = 400
) (
  input  logic               clk,
  input  logic               reset_p,
  ultrasonic_ranger_if.slave bus
);

  localparam int PRE        = CLK_HZ / 1_000_000;
  localparam int PERIOD_CYC = PERIOD_MS * 1000 * PRE;
  localparam int PRE_W      = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int PER_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int TRG_W      = $clog2(TRIG_US + 1);
  localparam int TO_W       = $clog2(TIMEOUT_US + 1);
  localparam int SUB_W      = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam int CM_W       = $clog2(NO_ECHO_CM + 1);

  if (CLK_HZ < 1_000_000 || (CLK_HZ % 1_000_000) != 0) begin : g_bad_clk
    $error("ultrasonic_ranger: CLK_HZ must be a whole multiple of 1 MHz");
  end

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_RISE, MEASURE, DONE_OK, DONE_TO
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        echo_q;            // [1:0] synchroniser, [2] edge register
  logic [PRE_W-1:0]  pre_q, pre_d;      // µs prescaler
  logic [PER_W-1:0]  per_q, per_d;      // trigger period, in clk cycles
  logic [TRG_W-1:0]  trg_q, trg_d;      // trigger width, in µs
  logic [TO_W-1:0]   to_q, to_d;        // µs since trigger fall
  logic [SUB_W-1:0]  sub_q, sub_d;      // µs within the current cm
  logic [CM_W-1:0]   cm_q, cm_d;        // whole cm measured so far
  logic [15:0]       dist_q, dist_d;
  logic              tof_q, tof_d;      // sticky timeout flag
  logic              pre_clr;

  logic echo_rise, echo_fall, tick, per_wrap, to_hit;

  // Edges are taken on the synchronised copy. They appear 2 clk after the pin moves.
  assign echo_rise = echo_q[1] & ~echo_q[2];
  assign echo_fall = ~echo_q[1] & echo_q[2];

  assign tick = (pre_q == PRE_W'(PRE - 1));

  // The period counter counts raw clocks (PRE per µs) so that the prescaler
  // restarts at TRIG entry and echo rise cannot shift the trigger cadence.
  // It wraps freely, so a boundary missed while busy is simply skipped.
  assign per_wrap = (per_q == PER_W'(PERIOD_CYC - 1));
  assign per_d    = per_wrap ? '0 : per_q + 1'b1;

  // This tick makes the timeout count reach TIMEOUT_US.
  assign to_hit = tick && (to_q == TO_W'(TIMEOUT_US - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    if (pre_clr) pre_d = '0;
  end

  always_comb begin
    state_d = state_q;
    trg_d   = trg_q;
    to_d    = to_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    dist_d  = dist_q;
    tof_d   = tof_q;
    pre_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && per_wrap) begin
          state_d = TRIG;
          trg_d   = '0;
          to_d    = '0;
          pre_clr = 1'b1;
        end
      end
      TRIG: begin
        if (tick) begin
          if (trg_q == TRG_W'(TRIG_US - 1)) state_d = WAIT_RISE;
          else                              trg_d   = trg_q + 1'b1;
        end
      end
      WAIT_RISE: begin
        if (tick) to_d = to_q + 1'b1;
        if (to_hit) begin
          state_d = DONE_TO;
          dist_d  = 16'(NO_ECHO_CM);
          tof_d   = 1'b1;
        end else if (echo_rise) begin
          state_d = MEASURE;
          cm_d    = '0;
          sub_d   = '0;
          pre_clr = 1'b1;
        end
      end
      MEASURE: begin
        if (tick) begin
          to_d = to_q + 1'b1;
          if (sub_q == SUB_W'(US_PER_CM - 1)) begin
            sub_d = '0;
            if (cm_q != CM_W'(NO_ECHO_CM)) cm_d = cm_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        // The result is loaded on the way into DONE_*. That gives a pin-to-valid
        // latency of 3 clk. The fall cycle's own tick is included via cm_d,
        // so MEASURE spans exactly the echo width in clocks.
        if (to_hit) begin
          state_d = DONE_TO;
          dist_d  = 16'(NO_ECHO_CM);
          tof_d   = 1'b1;
        end else if (echo_fall) begin
          state_d = DONE_OK;
          dist_d  = 16'(cm_d);
          tof_d   = 1'b0;
        end
      end
      DONE_OK, DONE_TO: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      echo_q  <= '0;
      pre_q   <= '0;
      per_q   <= '0;
      trg_q   <= '0;
      to_q    <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      dist_q  <= '0;
      tof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      echo_q  <= {echo_q[1:0], bus.echo};
      pre_q   <= pre_d;
      per_q   <= per_d;
      trg_q   <= trg_d;
      to_q    <= to_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      dist_q  <= dist_d;
      tof_q   <= tof_d;
    end
  end

  // The outputs decode the state register, so reset clears trig/busy/valid at once.
  assign bus.trig        = (state_q == TRIG);
  assign bus.busy        = (state_q == TRIG) || (state_q == WAIT_RISE) || (state_q == MEASURE);
  assign bus.valid       = (state_q == DONE_OK) || (state_q == DONE_TO);
  assign bus.distance_cm = dist_q;
  assign bus.timeout     = tof_q;

endmodule
